// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and nibble constants
package nibble_serial_adder_pkg;

    localparam int NW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_add4_ci.sv
// add4_ci: combinational 4-bit adder with carry-in
module add4_ci
    import nibble_serial_adder_pkg::*;
(
    input  logic [NW-1:0] x0,
    input  logic [NW-1:0] x1,
    input  logic          ci,
    output logic [NW:0]   o
);

    assign o = {1'b0, x0} + {1'b0, x1} + {{NW{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide unsigned adder using one 4-bit slice, one nibble per clock
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NW*NIBBLES-1:0]  a,
    input  logic [NW*NIBBLES-1:0]  b,
    output logic                   busy,
    output logic                   done,
    output logic [NW*NIBBLES:0]    sum
);

    localparam int W  = NW * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    state_t          state, nstate;
    logic [W-1:0]    a_r, b_r;
    logic            carry_r;
    logic [IW-1:0]   idx;
    logic [NW-1:0]   ax, bx;
    logic [NW:0]     s;
    logic            accept, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = idx == IW'(NIBBLES - 1);
    assign ax     = a_r[NW*idx +: NW];
    assign bx     = b_r[NW*idx +: NW];

    add4_ci u_add (.x0(ax), .x1(bx), .ci(carry_r), .o(s));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (state == RUN) nstate = last ? DONE : RUN;
        else              nstate = start ? RUN : IDLE;
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
        end else if (state == RUN) begin
            sum[NW*idx +: NW] <= s[NW-1:0];
            carry_r           <= s[NW];
            idx               <= last ? '0 : idx + 1'b1;
            if (last) sum[W] <= s[NW];
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks against a plain a+b model
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, start1 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        busy4, done4, busy1, done1;
    logic [16:0] sum4;
    logic [4:0]  sum1;
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at the current negedge, optionally pokes start mid-run, returns at the done cycle.
    task automatic go4(input logic [15:0] x, input logic [15:0] y, input int pulse_at, input string tag);
        int n, bc;
        logic [16:0] exp;
        exp = {1'b0, x} + {1'b0, y};
        a4 = x; b4 = y; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom);
        n = 1; bc = 0;
        while (!done4 && n < 20) begin
            if (busy4) bc++;
            if (n == pulse_at) begin start4 = 1'b1; a4 = 16'h0001; b4 = 16'h0001; end
            else start4 = 1'b0;
            @(negedge clk);
            n++;
        end
        start4 = 1'b0;
        chk({tag, " latency"}, n, 5);
        chk({tag, " busy_cycles"}, bc, 4);
        chk({tag, " sum"}, sum4, exp);
        chk({tag, " busy_in_done"}, busy4, 0);
    endtask

    task automatic go1(input logic [3:0] x, input logic [3:0] y);
        int n;
        a1 = x; b1 = y; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("n1 %0h+%0h latency", x, y), n, 2);
        chk($sformatf("n1 %0h+%0h sum", x, y), sum1, {1'b0, x} + {1'b0, y});
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy4", busy4, 0);
        chk("reset done4", done4, 0);
        chk("reset sum4", sum4, 0);
        chk("reset busy1", busy1, 0);
        chk("reset done1", done1, 0);
        chk("reset sum1", sum1, 0);
        @(negedge clk);
        go4(16'h0000, 16'h0000, 0, "zero");
        @(negedge clk);
        chk("idle after done", done4, 0);
        go4(16'hFFFF, 16'h0001, 0, "ripple");
        @(negedge clk);
        go4(16'h1234, 16'h4321, 0, "b2b first");
        go4(16'hFFFF, 16'hFFFF, 0, "b2b second");
        @(negedge clk);
        go4(16'h2345, 16'h6789, 2, "start while busy");
        dc = 0;
        repeat (10) begin @(negedge clk); if (done4) dc++; end
        chk("no extra done", dc, 0);
        a4 = 16'hFFFF; b4 = 16'hFFFF; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start4 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0;
        chk("midrun rst busy", busy4, 0);
        chk("midrun rst done", done4, 0);
        chk("midrun rst sum", sum4, 0);
        @(negedge clk);
        chk("rst ignores start", busy4, 0);
        go4(16'h000F, 16'h0001, 0, "fresh after rst");
        repeat (20) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            go4(16'($urandom), 16'($urandom), 0, "random");
        end
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                go1(4'(i), 4'(j));
                @(negedge clk);
            end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
